// File: rtl/phase_offset_clock_gen_if.sv
// Configuration channel for phase_offset_clock_gen.
//   cfg_period / cfg_high / cfg_offset : period P, high time H, lag D (clk cycles)
//   cfg_valid                          : config present (master -> slave)
//   cfg_ready                          : slave can accept this cycle
//   cfg_error                          : one-cycle pulse, accepted config was illegal
// The master drives the config. The generator is the slave.
interface phase_offset_clock_gen_if #(
  parameter int count_size = 12
);
  logic [count_size-1:0] cfg_period;
  logic [count_size-1:0] cfg_high;
  logic [count_size-1:0] cfg_offset;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic                  cfg_error;

  modport master (
    output cfg_period, cfg_high, cfg_offset, cfg_valid,
    input  cfg_ready, cfg_error
  );

  modport slave (
    input  cfg_period, cfg_high, cfg_offset, cfg_valid,
    output cfg_ready, cfg_error
  );
endinterface

// File: rtl/phase_offset_clock_gen.sv
// Programmable two-phase square-wave generator.
// clk_out_1 rises exactly D cycles after clk_out_0, and both outputs have period P
// and high time H. Config changes land only on period boundaries.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   enable      : 1 = run, 0 = stop at the end of the current period
//   cfg         : config handshake (slave modport)
//   running     : high in RUN or STOPPING
//   clk_out_0   : reference clock
//   clk_out_1   : lagging clock
//   edge_count  : clk_out_0 rising edges, counted modulo 2^edge_count_size
module phase_offset_clock_gen #(
  parameter int count_size      = 12,
  parameter int edge_count_size = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  phase_offset_clock_gen_if.slave    cfg,
  output logic                       running,
  output logic                       clk_out_0,
  output logic                       clk_out_1,
  output logic [edge_count_size-1:0] edge_count
);

  typedef logic [count_size-1:0]      cnt_t;
  typedef logic [edge_count_size-1:0] edge_t;
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  localparam cnt_t CNT_ONE = cnt_t'(1);
  localparam cnt_t DEF_P   = cnt_t'(2);
  localparam cnt_t DEF_H   = cnt_t'(1);

  function automatic logic cfg_legal(cnt_t p, cnt_t h, cnt_t d);
    return (p >= DEF_P) && (h != '0) && (h < p) && (d < p);
  endfunction

  // (c - d) mod p, with one spare bit so c + p never overflows.
  function automatic cnt_t phase_lag(cnt_t c, cnt_t p, cnt_t d);
    logic [count_size:0] t;
    t = {1'b0, c} + {1'b0, p} - {1'b0, d};
    if (t >= {1'b0, p}) t = t - {1'b0, p};
    return t[count_size-1:0];
  endfunction

  state_t state_q, state_d;
  cnt_t   cnt0_q, cnt0_d, cnt0_adv, cnt1;
  cnt_t   p_q, h_q, d_q, p_d, h_d, d_d;
  cnt_t   pp_q, ph_q, pd_q, pp_d, ph_d, pd_d;
  logic   pend_q, pend_d;
  logic   seen1_q, seen1_d;
  logic   out0_d, out1_d;
  logic   err_q, err_d;
  edge_t  edge_d;
  logic   last, ready_c, accept, legal;

  always_comb begin
    state_d  = state_q;
    cnt1     = phase_lag(cnt0_q, p_q, d_q);
    last     = (cnt0_q == p_q - CNT_ONE);
    cnt0_adv = last ? '0 : cnt0_q + CNT_ONE;
    ready_c  = !rst && ((state_q == IDLE) || ((state_q == RUN) && last));
    accept   = cfg.cfg_valid && ready_c;
    legal    = cfg_legal(cfg.cfg_period, cfg.cfg_high, cfg.cfg_offset);
    err_d    = accept && !legal;
    cnt0_d   = cnt0_q;
    seen1_d  = seen1_q;
    out0_d   = 1'b0;
    out1_d   = 1'b0;
    p_d      = p_q;
    h_d      = h_q;
    d_d      = d_q;
    pp_d     = pp_q;
    ph_d     = ph_q;
    pd_d     = pd_q;
    pend_d   = pend_q;
    edge_d   = edge_count;

    case (state_q)
      IDLE: begin
        cnt0_d  = '0;
        seen1_d = 1'b0;
        if (accept && legal) begin
          p_d = cfg.cfg_period;
          h_d = cfg.cfg_high;
          d_d = cfg.cfg_offset;
        end
        if (enable) state_d = RUN;
      end

      RUN: begin
        cnt0_d  = cnt0_adv;
        // seen1 masks the wrapped cnt1 values before the first clk_out_1 rise.
        seen1_d = seen1_q || (cnt1 == '0);
        out0_d  = (cnt0_q < h_q);
        out1_d  = (cnt1 < h_q) && seen1_d;
        if (last && !enable) begin
          state_d = STOPPING;
          // The stop finishes on the old timing, so park the new config.
          if (accept && legal) begin
            pp_d   = cfg.cfg_period;
            ph_d   = cfg.cfg_high;
            pd_d   = cfg.cfg_offset;
            pend_d = 1'b1;
          end
        end else if (accept && legal) begin
          p_d = cfg.cfg_period;
          h_d = cfg.cfg_high;
          d_d = cfg.cfg_offset;
        end
      end

      STOPPING: begin
        // cnt1 == 0 would begin a fresh clk_out_1 pulse (D = 0 case), so it ends the stop too.
        if ((cnt1 >= h_q) || (cnt1 == '0)) begin
          state_d = IDLE;
          cnt0_d  = '0;
          seen1_d = 1'b0;
          if (pend_q) begin
            p_d    = pp_q;
            h_d    = ph_q;
            d_d    = pd_q;
            pend_d = 1'b0;
          end
        end else begin
          cnt0_d = cnt0_adv;
          out1_d = seen1_q;
        end
      end

      default: state_d = IDLE;
    endcase

    if (out0_d && !clk_out_0) edge_d = edge_count + edge_t'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q     <= '0;
      seen1_q    <= 1'b0;
      clk_out_0  <= 1'b0;
      clk_out_1  <= 1'b0;
      edge_count <= '0;
      err_q      <= 1'b0;
      p_q        <= DEF_P;
      h_q        <= DEF_H;
      d_q        <= '0;
      pp_q       <= '0;
      ph_q       <= '0;
      pd_q       <= '0;
      pend_q     <= 1'b0;
    end else begin
      cnt0_q     <= cnt0_d;
      seen1_q    <= seen1_d;
      clk_out_0  <= out0_d;
      clk_out_1  <= out1_d;
      edge_count <= edge_d;
      err_q      <= err_d;
      p_q        <= p_d;
      h_q        <= h_d;
      d_q        <= d_d;
      pp_q       <= pp_d;
      ph_q       <= ph_d;
      pd_q       <= pd_d;
      pend_q     <= pend_d;
    end
  end

  assign running       = (state_q != IDLE);
  assign cfg.cfg_ready = ready_c;
  assign cfg.cfg_error = err_q;

endmodule

// File: tb/tb_phase_offset_clock_gen.sv
// Directed bench for phase_offset_clock_gen. Cycle k counts from the cycle
// in which enable is first sampled high (k = 0). Inputs are driven and outputs
// are sampled on the falling edge.
module tb_phase_offset_clock_gen;
  localparam int CS = 12;
  localparam int ES = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          running;
  logic          clk_out_0;
  logic          clk_out_1;
  logic [ES-1:0] edge_count;
  int            errors = 0;
  int            checks = 0;

  phase_offset_clock_gen_if #(.count_size(CS)) cfg_bus ();

  phase_offset_clock_gen #(.count_size(CS), .edge_count_size(ES)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cfg        (cfg_bus.slave),
    .running    (running),
    .clk_out_0  (clk_out_0),
    .clk_out_1  (clk_out_1),
    .edge_count (edge_count)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(negedge clk);
  endtask

  // Square wave whose first high cycle is `start`, with period p and high time h.
  function automatic logic wave(int k, int start, int p, int h);
    if (k < start) return 1'b0;
    return ((k - start) % p) < h;
  endfunction

  task automatic do_reset;
    rst = 1'b1; enable = 1'b0; cfg_bus.cfg_valid = 1'b0;
    cyc; cyc;
    rst = 1'b0;
    cyc;
  endtask

  task automatic load_cfg(input int p, input int h, input int d);
    cfg_bus.cfg_period = CS'(p);
    cfg_bus.cfg_high   = CS'(h);
    cfg_bus.cfg_offset = CS'(d);
    cfg_bus.cfg_valid  = 1'b1;
    cyc;
    cfg_bus.cfg_valid  = 1'b0;
  endtask

  task automatic stop_and_wait(output int n);
    enable = 1'b0; cfg_bus.cfg_valid = 1'b0; n = 0;
    while (running === 1'b1 && n < 100) begin
      cyc; n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_period = '0;
    cfg_bus.cfg_high = '0; cfg_bus.cfg_offset = '0;
    cyc; cyc;
    checks++;
    if ({clk_out_0, clk_out_1, running, cfg_bus.cfg_ready, cfg_bus.cfg_error, edge_count} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got o0=%b o1=%b run=%b rdy=%b err=%b ec=%0d want all 0",
               clk_out_0, clk_out_1, running, cfg_bus.cfg_ready, cfg_bus.cfg_error, edge_count);
    end
    rst = 1'b0;
    cyc;
    checks++;
    if ({cfg_bus.cfg_ready, running} !== 2'b10) begin
      errors++;
      $display("FAIL reset_idle_ready: got rdy=%b run=%b want 1 0", cfg_bus.cfg_ready, running);
    end
  endtask

  task automatic test_defaults;
    int e; logic e0, p0; int n;
    e = 0; p0 = 1'b0;
    enable = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      cyc;
      e0 = wave(k, 2, 2, 1);
      if (e0 && !p0) e = (e + 1) % 16;
      p0 = e0;
      checks++;
      if ({clk_out_0, clk_out_1, edge_count} !== {e0, e0, 4'(e)}) begin
        errors++;
        $display("FAIL defaults k=%0d: got o0=%b o1=%b ec=%0d want %b %b %0d",
                 k, clk_out_0, clk_out_1, edge_count, e0, e0, e);
      end
    end
    stop_and_wait(n);
    checks++;
    if (n >= 100 || {clk_out_0, clk_out_1, running} !== 3'b000) begin
      errors++;
      $display("FAIL defaults_stop: got cycles=%0d o0=%b o1=%b run=%b want idle with outputs 0",
               n, clk_out_0, clk_out_1, running);
    end
  endtask

  task automatic test_idle_cfg;
    logic e0, e1; int n;
    do_reset;
    load_cfg(10, 5, 3);
    checks++;
    if ({cfg_bus.cfg_error, running} !== 2'b00) begin
      errors++;
      $display("FAIL idle_cfg_load: got err=%b run=%b want 0 0", cfg_bus.cfg_error, running);
    end
    enable = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      cyc;
      e0 = wave(k, 2, 10, 5);
      e1 = wave(k, 5, 10, 5);
      checks++;
      if ({clk_out_0, clk_out_1} !== {e0, e1}) begin
        errors++;
        $display("FAIL idle_cfg k=%0d: got o0=%b o1=%b want %b %b", k, clk_out_0, clk_out_1, e0, e1);
      end
    end
    stop_and_wait(n);
    checks++;
    if (n >= 100 || {clk_out_0, clk_out_1, running} !== 3'b000) begin
      errors++;
      $display("FAIL idle_cfg_stop: got cycles=%0d o0=%b o1=%b run=%b want idle", n, clk_out_0, clk_out_1, running);
    end
  endtask

  task automatic test_run_cfg;
    logic e0, e1; int n;
    do_reset;
    load_cfg(10, 5, 3);
    cfg_bus.cfg_period = CS'(10); cfg_bus.cfg_high = CS'(5); cfg_bus.cfg_offset = CS'(7);
    enable = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      cyc;
      e0 = wave(k, 2, 10, 5);
      e1 = (k <= 11) ? wave(k, 5, 10, 5) : (((k + 1) % 10) < 5);
      checks++;
      if ({clk_out_0, clk_out_1} !== {e0, e1}) begin
        errors++;
        $display("FAIL run_cfg k=%0d: got o0=%b o1=%b want %b %b", k, clk_out_0, clk_out_1, e0, e1);
      end
      if (k >= 3 && k <= 10) begin
        checks++;
        if (cfg_bus.cfg_ready !== (k == 10)) begin
          errors++;
          $display("FAIL run_cfg_ready k=%0d: got %b want %b", k, cfg_bus.cfg_ready, (k == 10));
        end
      end
      if (k == 11) begin
        checks++;
        if (cfg_bus.cfg_error !== 1'b0) begin
          errors++;
          $display("FAIL run_cfg_error: got %b want 0", cfg_bus.cfg_error);
        end
      end
      cfg_bus.cfg_valid = (k >= 3 && k <= 10);
    end
    stop_and_wait(n);
    checks++;
    if (n >= 100 || running !== 1'b0) begin
      errors++;
      $display("FAIL run_cfg_stop: got cycles=%0d run=%b want idle", n, running);
    end
  endtask

  task automatic test_illegal;
    int ip[4]; int ih[4]; int id[4];
    logic e0, e1, ee; int idx; int n;
    ip = '{10, 10, 1, 10};
    ih = '{0, 10, 1, 5};
    id = '{3, 3, 0, 10};
    do_reset;
    load_cfg(10, 5, 3);
    enable = 1'b1;
    for (int k = 1; k <= 46; k++) begin
      cyc;
      e0 = wave(k, 2, 10, 5);
      e1 = wave(k, 5, 10, 5);
      ee = (k >= 11 && k <= 41 && ((k - 1) % 10) == 0);
      checks++;
      if ({clk_out_0, clk_out_1, cfg_bus.cfg_error} !== {e0, e1, ee}) begin
        errors++;
        $display("FAIL illegal k=%0d: got o0=%b o1=%b err=%b want %b %b %b",
                 k, clk_out_0, clk_out_1, cfg_bus.cfg_error, e0, e1, ee);
      end
      if (k <= 40) begin
        idx = (k - 1) / 10;
        cfg_bus.cfg_period = CS'(ip[idx]);
        cfg_bus.cfg_high   = CS'(ih[idx]);
        cfg_bus.cfg_offset = CS'(id[idx]);
        cfg_bus.cfg_valid  = 1'b1;
      end else begin
        cfg_bus.cfg_valid  = 1'b0;
      end
    end
    stop_and_wait(n);
    checks++;
    if (n >= 100 || running !== 1'b0) begin
      errors++;
      $display("FAIL illegal_stop: got cycles=%0d run=%b want idle", n, running);
    end
  endtask

  // Ends with the generator running P=4, H=2, D=1 and both outputs high.
  task automatic test_stop;
    logic e0, e1, er;
    do_reset;
    load_cfg(10, 5, 8);
    enable = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      cyc;
      e0 = wave(k, 2, 10, 5) && (k <= 21);
      e1 = (k >= 10 && k <= 14) || (k >= 20 && k <= 24);
      er = (k <= 24);
      checks++;
      if ({clk_out_0, clk_out_1, running} !== {e0, e1, er}) begin
        errors++;
        $display("FAIL stop k=%0d: got o0=%b o1=%b run=%b want %b %b %b",
                 k, clk_out_0, clk_out_1, running, e0, e1, er);
      end
      if (k == 20) begin
        checks++;
        if (cfg_bus.cfg_ready !== 1'b1) begin
          errors++;
          $display("FAIL stop_cfg_ready: got %b want 1", cfg_bus.cfg_ready);
        end
      end
      if (k == 25) begin
        checks++;
        if ({cfg_bus.cfg_error, edge_count} !== {1'b0, 4'd2}) begin
          errors++;
          $display("FAIL stop_final: got err=%b ec=%0d want 0 2", cfg_bus.cfg_error, edge_count);
        end
      end
      if (k == 15) enable = 1'b0;
      cfg_bus.cfg_period = CS'(4); cfg_bus.cfg_high = CS'(2); cfg_bus.cfg_offset = CS'(1);
      cfg_bus.cfg_valid  = (k == 20);
    end
    enable = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      cyc;
      e0 = wave(j, 2, 4, 2);
      e1 = wave(j, 3, 4, 2);
      checks++;
      if ({clk_out_0, clk_out_1} !== {e0, e1}) begin
        errors++;
        $display("FAIL stop_newcfg j=%0d: got o0=%b o1=%b want %b %b", j, clk_out_0, clk_out_1, e0, e1);
      end
    end
  endtask

  task automatic test_reset_mid;
    int e; logic e0, p0; int n;
    rst = 1'b1;
    cyc;
    checks++;
    if ({clk_out_0, clk_out_1, running, cfg_bus.cfg_ready, cfg_bus.cfg_error, edge_count} !== 9'b0) begin
      errors++;
      $display("FAIL reset_mid: got o0=%b o1=%b run=%b rdy=%b err=%b ec=%0d want all 0",
               clk_out_0, clk_out_1, running, cfg_bus.cfg_ready, cfg_bus.cfg_error, edge_count);
    end
    rst = 1'b0;
    e = 0; p0 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc;
      e0 = wave(k, 2, 2, 1);
      if (e0 && !p0) e = e + 1;
      p0 = e0;
      checks++;
      if ({clk_out_0, clk_out_1, running, edge_count} !== {e0, e0, 1'b1, 4'(e)}) begin
        errors++;
        $display("FAIL reset_mid_defaults k=%0d: got o0=%b o1=%b run=%b ec=%0d want %b %b 1 %0d",
                 k, clk_out_0, clk_out_1, running, edge_count, e0, e0, e);
      end
    end
    stop_and_wait(n);
    checks++;
    if (n >= 100 || running !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stop: got cycles=%0d run=%b want idle", n, running);
    end
  endtask

  initial begin
    test_reset;
    test_defaults;
    test_idle_cfg;
    test_run_cfg;
    test_illegal;
    test_stop;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/phase_offset_clock_gen.md
Name: phase_offset_clock_gen

Overview:
- Generates two clock-like square waves, clk_out_0 and clk_out_1, in the clk domain.
- Period, high time and clk_out_1 lag (in clk cycles) are programmable.
- Serves as the stimulus/transmit end for the start-stop phase detector: clk_out_1 rises exactly cfg offset cycles after clk_out_0.
- Config is loaded via a valid/ready handshake and applied only on period boundaries, so running outputs never glitch mid-period.

Parameters:
- count_size, 12, width of period/high/offset fields and internal phase counters
- edge_count_size, 4, width of the free-running clk_out_0 rising-edge counter (matches the detector's clk_0 count field)

Ports:
- clk  input  1  sample/generation clock
- rst  input  1  synchronous active-high reset
- enable  input  1  level; 1 = run, 0 = stop at the end of the current period
- cfg_period  input  count_size  period P in clk cycles
- cfg_high  input  count_size  high time H in clk cycles
- cfg_offset  input  count_size  clk_out_1 lag D in clk cycles
- cfg_valid  input  1  config present
- cfg_ready  output  1  config accepted when cfg_valid & cfg_ready
- cfg_error  output  1  one-cycle pulse: accepted config was illegal and was discarded
- running  output  1  1 while in RUN or STOPPING
- clk_out_0  output  1  generated reference clock
- clk_out_1  output  1  generated lagging clock
- edge_count  output  edge_count_size  number of clk_out_0 rising edges emitted, mod 2^edge_count_size

Behaviour:
- Reset (synchronous): state=IDLE; clk_out_0=clk_out_1=0; cfg_ready=0; cfg_error=0; running=0; edge_count=0; active config P=2, H=1, D=0; counters=0.
- Legal config: P>=2, 1<=H<=P-1, D<=P-1. An illegal accepted config pulses cfg_error the next cycle; the active config is unchanged.
- Handshake:
  - IDLE: cfg_ready=1.
  - RUN: cfg_ready=1 only in the cycle where cnt0==P-1 (last cycle of a period).
  - STOPPING: cfg_ready=0.
  - A config accepted in RUN takes effect from the next period (cnt0=0). A config accepted in IDLE takes effect immediately.
- Counters: cnt0 counts 0..P-1 and wraps. cnt1=(cnt0-D) mod P, computed in count_size+1 bits, no overflow.
- Outputs are registered:
  - clk_out_0 <= (cnt0 < H).
  - clk_out_1 <= (cnt1 < H) & seen1.
  - seen1 is cleared on RUN entry and set the first cycle cnt1==0. This suppresses the spurious clk_out_1 high in cycles 0..D-1 of the first period.
- Latency: if enable is sampled 1 in IDLE at cycle T, state=RUN and cnt0=0 at T+1. The first clk_out_0 rising edge appears at T+2, and the first clk_out_1 rising edge at T+2+D. Both repeat every P cycles.
- edge_count increments in the same cycle clk_out_0 registers a 0->1 transition, and wraps naturally.
- FSM:
  - IDLE -> RUN on enable.
  - RUN -> STOPPING when enable=0. The stop is taken at the next cnt0==P-1.
  - STOPPING: clk_out_0 is forced low. Counting continues until clk_out_1 has completed its high phase, i.e. until cnt1 >= H, max P cycles. Then go to IDLE with both outputs 0.
  - enable reasserting in STOPPING does not abort the stop; IDLE re-enters RUN on the next cycle.
- Simultaneous cfg accept and enable=0 at cnt0==P-1: the config is stored. The stop still proceeds using the old config during STOPPING, and the new config is used on the next RUN.
- D=0: clk_out_1 is identical to clk_out_0 every cycle.
- Reset mid-operation: all outputs are 0 on the cycle after rst is sampled, and the config returns to its defaults.

Test Plan:
1. Reset, then enable=1 at T with defaults (P=2, H=1, D=0) -> clk_out_0=clk_out_1 toggle 1,0,1,0 from T+2; edge_count increments every 2 cycles and wraps 15->0.
2. In IDLE, load P=10, H=5, D=3, then enable -> clk_out_0 high cycles T+2..T+6, clk_out_1 high T+5..T+9. clk_out_1 is not high during T+2..T+4 of the first period.
3. In RUN with P=10, hold cfg_valid with D=7 -> cfg_ready only at cnt0==9. The new lag of 7 is observed from the following period; clk_out_0 period is unchanged.
4. Illegal configs H=0, H=P, P=1, D=P -> cfg_ready accepts each, cfg_error pulses once per config, and the waveform is unchanged.
5. P=10, H=5, D=8: drop enable mid-period -> the current period completes, clk_out_0 stays low afterwards, clk_out_1 finishes its high phase, then running=0 and both outputs are 0.
6. Assert rst during RUN -> the next cycle has all outputs 0, state IDLE, and the config is back to P=2, H=1, D=0.
